tros_frame_serializer: RTL and testbench

//  Readout stage fed by the per-oscillator frequency counters: selects one latched cycle count and frames it.

---
 rtl/tros_readout_pkg.sv | 25 ++
 rtl/tros_crc8_serial.sv | 24 ++
 rtl/tros_frame_serializer.sv | 179 +++++++++++++++++
 tb/tb_tros_frame_serializer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tros_readout_pkg.sv
// Shared types and constants for the TROS readout path.
// Used by tros_frame_serializer and tros_crc8_serial.
package tros_readout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CRC,
    GAP
  } state_t;

  localparam logic [3:0] PREAMBLE  = 4'b1010;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam int         CHAN_W    = 2;

  function automatic logic [7:0] crc8_step(
    input logic [7:0] crc,
    input logic       bit_in
  );
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/tros_crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0, no reflection).
// Present only in builds with TROS_FRAME_CRC8_EN.
module tros_crc8_serial
  import tros_readout_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/tros_frame_serializer.sv
// Frames a selected cycle count onto a Manchester line.
// Optional CRC-8 trailer: define TROS_FRAME_CRC8_EN.
module tros_frame_serializer
  import tros_readout_pkg::*;
#(
  parameter int COUNTER_LENGTH = 20,
  parameter int NR_CHANNELS    = 3,
  parameter int SYNC_STAGES    = 3,
  parameter int GAP_CYCLES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic send_req,
  input  logic [CHAN_W-1:0] chan_sel,
  input  logic [NR_CHANNELS*COUNTER_LENGTH-1:0] cycle_counts,
  output logic data_stream,
  output logic busy,
  output logic frame_done
);

  localparam int HDR_W = 4 + CHAN_W;
  localparam int SH_W  = HDR_W + COUNTER_LENGTH;
  localparam int MAX_A = (SH_W > 8) ? SH_W : 8;
  localparam int MAX_C =
    (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] SH_LAST  =
    CNT_W'(SH_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYCLES - 1);
`ifdef TROS_FRAME_CRC8_EN
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] PAY_FIRST = CNT_W'(4);
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   req_edge;

  state_t              state_q, state_n;
  logic [SH_W-1:0]     shreg_q, shreg_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                tx_q, tx_n;
  logic                done_q, done_n;
  logic [COUNTER_LENGTH-1:0] sel_count;

`ifdef TROS_FRAME_CRC8_EN
  logic       crc_clr;
  logic       crc_en;
  logic [7:0] crc_val;

  tros_crc8_serial u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (shreg_q[SH_W-1]),
    .crc    (crc_val)
  );
`endif

  // send_req is asynchronous; prev_q turns the synced level into a pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], send_req};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign req_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    sel_count = '0;
    for (int k = 0; k < NR_CHANNELS; k++) begin
      if (chan_sel == CHAN_W'(k)) begin
        sel_count =
          cycle_counts[k*COUNTER_LENGTH +: COUNTER_LENGTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      shreg_q <= shreg_n;
      cnt_q   <= cnt_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

  // With ena low everything holds, so the frame resumes in place
  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    cnt_n   = cnt_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
`ifdef TROS_FRAME_CRC8_EN
    crc_clr = 1'b0;
    crc_en  = 1'b0;
`endif
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          tx_n = 1'b0;
          if (req_edge) begin
            state_n = SHIFT;
            shreg_n = {PREAMBLE, chan_sel, sel_count};
            cnt_n   = '0;
`ifdef TROS_FRAME_CRC8_EN
            crc_clr = 1'b1;
`endif
          end
        end
        SHIFT: begin
          tx_n    = shreg_q[SH_W-1];
          shreg_n = {shreg_q[SH_W-2:0], 1'b0};
          cnt_n   = cnt_q + 1'b1;
`ifdef TROS_FRAME_CRC8_EN
          crc_en  = (cnt_q >= PAY_FIRST);
`endif
          if (cnt_q == SH_LAST) begin
            cnt_n = '0;
`ifdef TROS_FRAME_CRC8_EN
            state_n = CRC;
`else
            state_n = GAP;
`endif
          end
        end
        CRC: begin
`ifdef TROS_FRAME_CRC8_EN
          tx_n  = crc_val[~cnt_q[2:0]];
          cnt_n = cnt_q + 1'b1;
          if (cnt_q == CRC_LAST) begin
            cnt_n   = '0;
            state_n = GAP;
          end
`else
          tx_n    = 1'b0;
          cnt_n   = '0;
          state_n = GAP;
`endif
        end
        GAP: begin
          tx_n  = 1'b0;
          cnt_n = cnt_q + 1'b1;
          if (cnt_q == GAP_LAST) begin
            cnt_n   = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          tx_n    = 1'b0;
        end
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign data_stream = (tx_q & ena) ^ clk;

endmodule

// File: tb/tb_tros_frame_serializer.sv
// Directed bench for tros_frame_serializer.
// Frame checks widen to 34 bits with TROS_FRAME_CRC8_EN.
module tb_tros_frame_serializer;

  localparam int CL  = 20;
  localparam int NC  = 3;
  localparam int S   = 3;
  localparam int GAP = 2;
`ifdef TROS_FRAME_CRC8_EN
  localparam int FLEN = 34;
`else
  localparam int FLEN = 26;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic send_req;
  logic [1:0] chan_sel;
  logic [NC*CL-1:0] cycle_counts;
  logic data_stream;
  logic busy;
  logic frame_done;

  int total = 0;
  int bad   = 0;

  logic [NC*CL-1:0] cnts;

  tros_frame_serializer #(
    .COUNTER_LENGTH (CL),
    .NR_CHANNELS    (NC),
    .SYNC_STAGES    (S),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .send_req     (send_req),
    .chan_sel     (chan_sel),
    .cycle_counts (cycle_counts),
    .data_stream  (data_stream),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  function automatic logic [FLEN-1:0] exp_frame(
    input logic [1:0]  ch,
    input logic [19:0] c
  );
    logic [25:0] base;
    base = {4'b1010, ch, c};
`ifdef TROS_FRAME_CRC8_EN
    begin
      logic [7:0] r;
      logic fb;
      r = 8'h00;
      for (int i = 21; i >= 0; i--) begin
        fb = r[7] ^ base[i];
        r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return {base, r};
    end
`else
    return base;
`endif
  endfunction

  task automatic run_frame(
    input string          name,
    input logic [1:0]     ch,
    input logic [59:0]    counts,
    input logic [FLEN-1:0] exp,
    input int             mid_at,
    input bit             hold
  );
    logic [FLEN-1:0] got;
    int nb, nd, done_at, last;
    got = '0; nb = 0; nd = 0; done_at = -1;
    last = S + 1 + FLEN + GAP;
    @(negedge clk);
    chan_sel = ch;
    cycle_counts = counts;
    send_req = 1'b1;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      if (i == 2 && !hold) send_req = 1'b0;
      if (mid_at >= 0 && i == S + 2 + mid_at)
        send_req = 1'b1;
      if (mid_at >= 0 && i == S + 4 + mid_at)
        send_req = 1'b0;
      if (i == S) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL %s_busy_early: got %b want 0",
                   name, busy);
        end
      end
      if (i == S + 1) begin
        total++;
        if (busy !== 1'b1 || data_stream !== 1'b0) begin
          bad++;
          $display("FAIL %s_load: busy %b line %b want 1 0",
                   name, busy, data_stream);
        end
      end
      if (i == S + 2) begin
        cycle_counts = ~counts;
        chan_sel = ~ch;
      end
      if (i >= S + 2 && i < S + 2 + FLEN)
        got = {got[FLEN-2:0], data_stream};
      if (i == S + 2 + FLEN) begin
        total++;
        if (data_stream !== 1'b0) begin
          bad++;
          $display("FAIL %s_gap_line: got %b want 0",
                   name, data_stream);
        end
      end
      if (busy === 1'b1) nb++;
      if (frame_done === 1'b1) begin
        nd++;
        done_at = i;
      end
    end
    if (hold) send_req = 1'b0;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s_bits: got %h want %h", name, got, exp);
    end
    total++;
    if (nb != FLEN + GAP) begin
      bad++;
      $display("FAIL %s_busy_len: got %0d want %0d",
               name, nb, FLEN + GAP);
    end
    total++;
    if (nd != 1 || done_at != last) begin
      bad++;
      $display("FAIL %s_done: n %0d at %0d want 1 at %0d",
               name, nd, done_at, last);
    end
  endtask

  task automatic idle_check(input string name, input int n);
    int nb, nd;
    nb = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
      if (frame_done === 1'b1) nd++;
    end
    total++;
    if (nb != 0 || nd != 0) begin
      bad++;
      $display("FAIL %s: busy %0d done %0d want 0 0",
               name, nb, nd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; send_req = 1'b0;
    chan_sel = 2'd0; cycle_counts = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0 ||
        data_stream !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: b %b d %b l %b want 0 0 0",
               busy, frame_done, data_stream);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (data_stream !== 1'b1) begin
        bad++;
        $display("FAIL idle_line_hi: got %b want 1",
                 data_stream);
      end
      @(negedge clk);
      total++;
      if (data_stream !== 1'b0 || busy !== 1'b0 ||
          frame_done !== 1'b0) begin
        bad++;
        $display("FAIL idle_lo: l %b b %b d %b want 0 0 0",
                 data_stream, busy, frame_done);
      end
    end
  endtask

  task automatic test_basic();
    run_frame("basic", 2'd1, cnts,
              exp_frame(2'b01, 20'hABCDE), -1, 1'b0);
  endtask

  task automatic test_crc();
    logic [FLEN-1:0] e0, e1;
    e0 = exp_frame(2'b00, 20'h00000);
    e1 = exp_frame(2'b00, 20'h00001);
`ifdef TROS_FRAME_CRC8_EN
    total++;
    if (e0[7:0] !== 8'h00 || e1[7:0] !== 8'h07) begin
      bad++;
      $display("FAIL crc_model: got %h %h want 00 07",
               e0[7:0], e1[7:0]);
    end
`endif
    run_frame("zero", 2'd0, {40'h0, 20'h00000},
              e0, -1, 1'b0);
    run_frame("one", 2'd0, {40'h0, 20'h00001},
              e1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame("mid", 2'd1, cnts,
              exp_frame(2'b01, 20'hABCDE), 8, 1'b0);
    idle_check("mid_dropped", 12);
    run_frame("hold", 2'd2, cnts,
              exp_frame(2'b10, 20'h12345), -1, 1'b1);
    idle_check("hold_no_retrig", 12);
    run_frame("b2b_a", 2'd0, cnts,
              exp_frame(2'b00, 20'h0F0F0), -1, 1'b0);
    run_frame("b2b_b", 2'd1, cnts,
              exp_frame(2'b01, 20'hABCDE), -1, 1'b0);
  endtask

  task automatic test_bad_chan();
    run_frame("chan3", 2'd3, cnts,
              exp_frame(2'b11, 20'h00000), -1, 1'b0);
  endtask

  task automatic test_ena();
    logic [FLEN-1:0] got;
    int nd;
    got = '0; nd = 0;
    @(negedge clk);
    chan_sel = 2'd1;
    cycle_counts = cnts;
    send_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    send_req = 1'b0;
    repeat (S - 1) @(negedge clk);
    for (int j = 0; j < FLEN; j++) begin
      @(negedge clk);
      if (j == 10) begin
        ena = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
          total++;
          if (data_stream !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ena_low_lo: l %b b %b want 0 1",
                     data_stream, busy);
          end
          @(posedge clk);
          #1;
          total++;
          if (data_stream !== 1'b1) begin
            bad++;
            $display("FAIL ena_low_hi: got %b want 1",
                     data_stream);
          end
          @(negedge clk);
        end
        ena = 1'b1;
        #1;
      end
      got = {got[FLEN-2:0], data_stream};
    end
    for (int i = 0; i < GAP + 3; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) nd++;
    end
    total++;
    if (got !== exp_frame(2'b01, 20'hABCDE)) begin
      bad++;
      $display("FAIL ena_bits: got %h want %h",
               got, exp_frame(2'b01, 20'hABCDE));
    end
    total++;
    if (nd != 1) begin
      bad++;
      $display("FAIL ena_done: got %0d want 1", nd);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    chan_sel = 2'd1;
    cycle_counts = cnts;
    send_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    send_req = 1'b0;
    repeat (S + 4) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || data_stream !== 1'b0 ||
        frame_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_abort: b %b l %b d %b want 0 0 0",
               busy, data_stream, frame_done);
    end
    rst_n = 1'b1;
    idle_check("rst_no_done", 40);
  endtask

  initial begin
    cnts = {20'h12345, 20'hABCDE, 20'h0F0F0};
    test_reset();
    test_basic();
    test_crc();
    test_back_to_back();
    test_bad_chan();
    test_ena();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
